// File: rtl/cycle_scheduler.sv
// cycle_scheduler: steps the three LED cycle channels through a fixed
// four-entry speed pattern table. Advances come from a debounced button
// press or from a dwell timer; every change restarts all channels together.
module cycle_scheduler #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DWELL_CYCLES    = 48000000,
  parameter int RESTART_CYCLES  = 4,
  parameter int SPEED_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic               auto_en,
  output logic [SPEED_W-1:0] speed_r,
  output logic [SPEED_W-1:0] speed_g,
  output logic [SPEED_W-1:0] speed_b,
  output logic [2:0]         ch_rst,
  output logic [1:0]         pattern
);

  localparam logic [0:0] ST_RESTART = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  // Each counter only needs to reach (parameter - 1).
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW_W = (DWELL_CYCLES > 1)    ? $clog2(DWELL_CYCLES)    : 1;
  localparam int RS_W = (RESTART_CYCLES > 1)  ? $clog2(RESTART_CYCLES)  : 1;

  // Pattern table lookup; channel 0 = red, 1 = green, 2 = blue.
  function automatic logic [SPEED_W-1:0] table_speed(input logic [1:0] pat, input int ch);
    logic [SPEED_W-1:0] v;
    v = '0;
    case (pat)
      2'd0: begin
        if (ch == 0)      v = SPEED_W'(1301);
        else if (ch == 1) v = SPEED_W'(1607);
        else              v = SPEED_W'(1999);
      end
      2'd1: v = SPEED_W'(1607);
      2'd2: v = (ch == 0) ? SPEED_W'(1301) : '0;
      default: v = (ch == 2) ? SPEED_W'(1999) : '0;
    endcase
    return v;
  endfunction

  logic              sync1_reg, sync2_reg;
  logic              db_reg, db_prev_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [0:0]        state_reg;
  logic [RS_W-1:0]   rs_cnt_reg;
  logic [DW_W-1:0]   dwell_reg;
  logic [1:0]        pattern_reg;
  logic [2:0]        ch_rst_reg;
  logic [SPEED_W-1:0] speed_reg [3];
  logic [2:0]        park;
  logic [1:0]        pattern_next;
  logic              press, expire, advance;

  assign pattern_next = pattern_reg + 2'd1;
  assign press        = db_reg & ~db_prev_reg;
  assign expire       = (state_reg == ST_RUN) && auto_en &&
                        (dwell_reg == DW_W'(DWELL_CYCLES - 1));
  assign advance      = (state_reg == ST_RUN) && (press || expire);

  // Synchronize the raw button and accept a new level only after it is stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      db_reg      <= 1'b0;
      db_prev_reg <= 1'b0;
      db_cnt_reg  <= '0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      db_prev_reg <= db_reg;
      if (sync2_reg != db_reg) begin
        if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_reg     <= sync2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // Per-channel speed registers and parked flags; speeds load only on advance.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign park[gi] = (speed_reg[gi] == '0);

      always_ff @(posedge clk) begin
        if (!rst)
          speed_reg[gi] <= table_speed(2'd0, gi);
        else if (advance)
          speed_reg[gi] <= table_speed(pattern_next, gi);
      end
    end
  endgenerate

  // RESTART/RUN sequencing, dwell timer and pattern stepping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_RESTART;
      rs_cnt_reg  <= '0;
      dwell_reg   <= '0;
      pattern_reg <= 2'd0;
      ch_rst_reg  <= 3'b111;
    end else begin
      case (state_reg)
        ST_RESTART: begin
          ch_rst_reg <= 3'b111;
          if (rs_cnt_reg == RS_W'(RESTART_CYCLES - 1)) begin
            state_reg  <= ST_RUN;
            rs_cnt_reg <= '0;
            ch_rst_reg <= park;
          end else begin
            rs_cnt_reg <= rs_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (advance) begin
            pattern_reg <= pattern_next;
            rs_cnt_reg  <= '0;
            dwell_reg   <= '0;
            state_reg   <= ST_RESTART;
            ch_rst_reg  <= 3'b111;
          end else begin
            ch_rst_reg <= park;
            if (auto_en)
              dwell_reg <= dwell_reg + 1'b1;
          end
        end
        default: state_reg <= ST_RESTART;
      endcase
    end
  end

  assign speed_r = speed_reg[0];
  assign speed_g = speed_reg[1];
  assign speed_b = speed_reg[2];
  assign ch_rst  = ch_rst_reg;
  assign pattern = pattern_reg;

endmodule

// File: tb/tb_cycle_scheduler.sv
// tb_cycle_scheduler: directed scenarios plus random stimulus, checked against
// a behavioural model (restart countdown, dwell count, debounce run length).
module tb_cycle_scheduler;

  localparam int DB = 4;
  localparam int DW = 20;
  localparam int RS = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn = 1'b0;
  logic          auto_en = 1'b0;
  logic [SW-1:0] speed_r, speed_g, speed_b;
  logic [2:0]    ch_rst;
  logic [1:0]    pattern;

  int errs = 0;
  int checks = 0;

  int tbl [4][3] = '{'{1301, 1607, 1999}, '{1607, 1607, 1607}, '{1301, 0, 0}, '{0, 0, 1999}};

  // Model state
  int m_pat = 0;
  int m_rl = RS;
  int m_dwell = 0;
  int m_run = 0;
  bit m_s1 = 0, m_s2 = 0, m_db = 0, m_dbp = 0;

  cycle_scheduler #(
    .DEBOUNCE_CYCLES(DB), .DWELL_CYCLES(DW), .RESTART_CYCLES(RS), .SPEED_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto_en(auto_en),
    .speed_r(speed_r), .speed_g(speed_g), .speed_b(speed_b),
    .ch_rst(ch_rst), .pattern(pattern)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] park_of(input int p);
    return {tbl[p][2] == 0, tbl[p][1] == 0, tbl[p][0] == 0};
  endfunction

  function automatic logic [2:0] exp_ch();
    if (m_rl > 0) return 3'b111;
    return park_of(m_pat);
  endfunction

  // One clock edge of the reference behaviour, using inputs present at the edge.
  function automatic void model_step(input bit r, input bit b, input bit ae);
    bit press, in_run, expire;
    if (!r) begin
      m_pat = 0; m_rl = RS; m_dwell = 0; m_run = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0;
    end else begin
      press  = m_db && !m_dbp;
      in_run = (m_rl == 0);
      expire = in_run && ae && (m_dwell == DW - 1);
      m_dbp = m_db;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
      if (in_run && (press || expire)) begin
        m_pat = (m_pat + 1) % 4;
        m_rl = RS;
        m_dwell = 0;
      end else if (!in_run) begin
        m_rl--;
      end else if (ae) begin
        m_dwell++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, btn, auto_en);
    #1;
  endtask

  task automatic test_reset();
    btn = 0; auto_en = 0; rst = 0;
    repeat (3) tick();
    checks++;
    if (pattern !== 2'd0) begin errs++; $display("FAIL reset_pattern: got %0d expected 0", pattern); end
    checks++;
    if (ch_rst !== 3'b111) begin errs++; $display("FAIL reset_ch_rst: got %b expected 111", ch_rst); end
    checks++;
    if (speed_r !== 16'd1301 || speed_g !== 16'd1607 || speed_b !== 16'd1999) begin
      errs++; $display("FAIL reset_speeds: got %0d/%0d/%0d expected 1301/1607/1999", speed_r, speed_g, speed_b);
    end
    rst = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (ch_rst !== ((i < 4) ? 3'b111 : 3'b000)) begin
        errs++; $display("FAIL reset_release_ch_rst[%0d]: got %b expected %b", i, ch_rst, (i < 4) ? 3'b111 : 3'b000);
      end
    end
  endtask

  task automatic test_bounce();
    int lat;
    bit seen;
    auto_en = 0;
    for (int c = 0; c < 20; c++) begin
      btn = ((c / 2) % 2 == 0);
      tick();
      checks++;
      if (pattern !== 2'd0) begin errs++; $display("FAIL bounce_no_advance[%0d]: got %0d expected 0", c, pattern); end
    end
    btn = 1;
    lat = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (pattern !== 2'd0) begin seen = 1; lat = k; end
    end
    checks++;
    if (!seen || lat != 7) begin errs++; $display("FAIL bounce_latency: got %0d expected 7 (seen=%0d)", lat, seen); end
    checks++;
    if (pattern !== 2'd1 || speed_r !== 16'd1607 || speed_g !== 16'd1607 || speed_b !== 16'd1607) begin
      errs++; $display("FAIL bounce_p1: got pat %0d %0d/%0d/%0d expected 1 1607x3", pattern, speed_r, speed_g, speed_b);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ch_rst !== ((k < 4) ? 3'b111 : 3'b000)) begin
        errs++; $display("FAIL bounce_restart[%0d]: got %b expected %b", k, ch_rst, (k < 4) ? 3'b111 : 3'b000);
      end
      tick();
    end
    btn = 0;
    repeat (10) tick();
    checks++;
    if (pattern !== 2'd1) begin errs++; $display("FAIL bounce_release: got %0d expected 1", pattern); end
  endtask

  task automatic test_parked();
    btn = 1;
    repeat (7) tick();
    checks++;
    if (pattern !== 2'd2) begin errs++; $display("FAIL parked_pattern: got %0d expected 2", pattern); end
    btn = 0;
    repeat (4) tick();
    checks++;
    if (ch_rst !== 3'b110) begin errs++; $display("FAIL parked_ch_rst: got %b expected 110", ch_rst); end
    checks++;
    if (speed_r !== 16'd1301 || speed_g !== 16'd0 || speed_b !== 16'd0) begin
      errs++; $display("FAIL parked_speeds: got %0d/%0d/%0d expected 1301/0/0", speed_r, speed_g, speed_b);
    end
    repeat (8) tick();
  endtask

  task automatic test_auto_wrap();
    int ep;
    logic [2:0] ec;
    btn = 0; auto_en = 1; rst = 0;
    tick();
    rst = 1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      ep = (i / (RS + DW)) % 4;
      ec = ((i % (RS + DW)) < RS) ? 3'b111 : park_of(ep);
      checks++;
      if (pattern !== 2'(ep)) begin errs++; $display("FAIL auto_pattern[%0d]: got %0d expected %0d", i, pattern, ep); end
      checks++;
      if (ch_rst !== ec) begin errs++; $display("FAIL auto_ch_rst[%0d]: got %b expected %b", i, ch_rst, ec); end
    end
    auto_en = 0;
  endtask

  task automatic test_simultaneous();
    btn = 0; auto_en = 1; rst = 0;
    tick();
    rst = 1;
    repeat (17) tick();
    btn = 1;
    for (int i = 18; i <= 30; i++) begin
      tick();
      checks++;
      if (pattern !== ((i >= 24) ? 2'd1 : 2'd0)) begin
        errs++; $display("FAIL simul_pattern[%0d]: got %0d expected %0d", i, pattern, (i >= 24) ? 1 : 0);
      end
    end
    btn = 0; auto_en = 0;
    repeat (8) tick();
    checks++;
    if (pattern !== 2'd1) begin errs++; $display("FAIL simul_single: got %0d expected 1", pattern); end
  endtask

  task automatic test_restart_events();
    btn = 0; auto_en = 1; rst = 0;
    tick();
    rst = 1;
    repeat (19) tick();
    btn = 1;
    for (int i = 20; i <= 40; i++) begin
      tick();
      checks++;
      if (pattern !== ((i >= 24) ? 2'd1 : 2'd0)) begin
        errs++; $display("FAIL restart_press_dropped[%0d]: got %0d expected %0d", i, pattern, (i >= 24) ? 1 : 0);
      end
    end
    btn = 0;
    repeat (9) tick();
    checks++;
    if (pattern !== 2'd2 || ch_rst !== 3'b111) begin
      errs++; $display("FAIL restart_p2: got pat %0d ch %b expected 2 111", pattern, ch_rst);
    end
    rst = 0;
    tick();
    checks++;
    if (pattern !== 2'd0 || ch_rst !== 3'b111 || speed_r !== 16'd1301 || speed_g !== 16'd1607 || speed_b !== 16'd1999) begin
      errs++; $display("FAIL restart_midreset: got pat %0d ch %b %0d/%0d/%0d expected 0 111 1301/1607/1999",
                       pattern, ch_rst, speed_r, speed_g, speed_b);
    end
    rst = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (ch_rst !== ((i < 4) ? 3'b111 : 3'b000)) begin
        errs++; $display("FAIL restart_recover[%0d]: got %b expected %b", i, ch_rst, (i < 4) ? 3'b111 : 3'b000);
      end
    end
    auto_en = 0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        btn = $urandom_range(0, 1);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      rst = ($urandom_range(0, 199) != 0);
      tick();
      checks++;
      if (pattern !== 2'(m_pat)) begin errs++; $display("FAIL random_pattern[%0d]: got %0d expected %0d", n, pattern, m_pat); end
      checks++;
      if (ch_rst !== exp_ch()) begin errs++; $display("FAIL random_ch_rst[%0d]: got %b expected %b", n, ch_rst, exp_ch()); end
      checks++;
      if (speed_r !== SW'(tbl[m_pat][0]) || speed_g !== SW'(tbl[m_pat][1]) || speed_b !== SW'(tbl[m_pat][2])) begin
        errs++; $display("FAIL random_speeds[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", n,
                         speed_r, speed_g, speed_b, tbl[m_pat][0], tbl[m_pat][1], tbl[m_pat][2]);
      end
    end
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_parked();
    test_auto_wrap();
    test_simultaneous();
    test_restart_events();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
